max_pool_relu_seq: RTL and testbench
====================================

# max_pool_relu_seq

Sequential 2x2 max-pooling plus ReLU stage that sits directly downstream of the multi-filter convolution layer. It consumes the flat convolution output bus of K feature maps, each HI x WI, one IEEE-754 single word at a time. It produces K maps of (HI/2) x (WI/2) in a registered flat output bus, with a start/busy/done handshake. Running max is seeded with +0.0, so ReLU comes at no extra cost.

## Interface
- DATA_WIDTH, 32, word width; IEEE-754 single.
- K, 6, number of feature maps (channels).
- HI, 28, input map height; must be even.
- WI, 28, input map width; must be even.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request to pool the current inputConv; sampled only in IDLE.
- inputConv  in  K*HI*WI*DATA_WIDTH  flat bus [0:...]. Element (k,r,c) is at word index (k*HI+r)*WI+c, bits [idx*DATA_WIDTH +: DATA_WIDTH]. Must stay stable from start until done.
- outputPool  out  K*(HI/2)*(WI/2)*DATA_WIDTH  registered flat bus [0:...]. Element (k,r,c) is at word index (k*HO+r)*WO+c, with HO=HI/2 and WO=WI/2.
- busy  out  1  high while windows are being processed.
- done  out  1  one-cycle pulse after the last window is written.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN when start=1. All counters clear.
- Counters in RUN:
  - elem: 0..3.
  - col: 0..WO-1.
  - row: 0..HO-1.
  - ch: 0..K-1.
  - Nesting: elem is innermost, then col, then row, then ch.
- Window (ch,row,col) element order:
  - elem0 = (2row, 2col)
  - elem1 = (2row, 2col+1)
  - elem2 = (2row+1, 2col)
  - elem3 = (2row+1, 2col+1)
- Running max m:
  - Treated as m=32'h0 at elem0; no separate init cycle.
  - Candidate x replaces m iff x[31]==0 and x[30:0] > m[30:0] (unsigned).
  - Negative values and -0.0 never win, so the result is max(0, window max) and is never negative.
- Write-back: at elem3, the final max (including elem3) is written to outputPool word (ch,row,col). Other words are unchanged.
- RUN -> DONE after elem3 of window (K-1, HO-1, WO-1).
- DONE -> IDLE unconditionally after one cycle.
- start ignored in RUN and DONE. No queuing.
- NaN/Inf: compared as bit patterns under the rule above. Positive NaN wins over any finite value; no special handling.
- Reset (any state, including mid-RUN): state=IDLE, counters=0, m=0, outputPool=all zeros, busy=0, done=0.
- Reset wins over a simultaneous start.

## Timing
- N = K*HO*WO windows; 4 cycles per window. Default N = 1176, run length 4704 cycles.
- start=1 in IDLE at cycle t.
- Window n occupies cycles t+1+4n .. t+4+4n. Element j is sampled in cycle t+1+4n+j.
- Output word n is visible from cycle t+5+4n.
- busy=1 in cycles t+1 .. t+4N; 0 otherwise.
- done=1 only in cycle t+4N+1. busy=0 in that cycle.
- IDLE from cycle t+4N+2. A start in cycle t+4N+2 is accepted.
- outputPool holds its values after done until overwritten word-by-word by the next run or cleared by reset.
- Reset values: busy=0, done=0, outputPool=0.

## Test plan
Small parameters for all scenarios unless noted: K=2, HI=WI=4, so N=8 and the run is 32 cycles.

- **Reset:** hold reset 2 cycles with arbitrary inputConv. Require outputPool==0, busy=0, done=0. start during reset must not start a run.
- **Ramp:** word idx = 32'(idx), positive bit patterns, start at t.
  - Require out(0,0,0)=5, out(0,1,1)=15, out(1,0,0)=21, out(1,1,1)=31.
  - Require busy high for exactly 32 cycles and done only at t+33.
  - Require word 0 updated at t+5 and word 7 at t+33.
- **All negative:** every word 32'hBF800000 (-1.0), with outputPool preloaded nonzero by a prior ramp run. Require every output word == 32'h00000000 after done.
- **Mixed window:** window (0,0,0) = {3F800000, C0000000, 40400000, 80000000}. Require out(0,0,0) = 40400000 (3.0). A window of all 80000000 (-0.0) must yield 00000000.
- **Handshake abuse:** pulse start at t+3, t+20 and t+33 (the done cycle). Require a single run, done exactly once at t+33, and state IDLE at t+34. A start at t+34 launches a new 32-cycle run.
- **Reset mid-run:** assert reset at cycle t+10.
  - Require busy=0 and outputPool==0 from t+11, and no done.
  - A new start after reset yields a full correct ramp result 32 cycles later.
- **Default parameters:** repeat the ramp scenario with K=6, HI=WI=28. Require done at t+4705 and out(5,13,13) = 32'(4703).

Source files
------------

// File: rtl/max_pool_relu_seq.sv
// Sequential 2x2 max-pool + ReLU over K feature maps, one input word per cycle.
// The running max is seeded with +0.0, so negative inputs never reach the output.
module max_pool_relu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 6,
    parameter int HI         = 28,
    parameter int WI         = 28
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [K*HI*WI*DATA_WIDTH-1:0]          inputConv,
    output logic [K*(HI/2)*(WI/2)*DATA_WIDTH-1:0]  outputPool,
    output logic                                   busy,
    output logic                                   done
);
    localparam int HO   = HI / 2;
    localparam int WO   = WI / 2;
    localparam int NIN  = K * HI * WI;
    localparam int NOUT = K * HO * WO;
    localparam int IW   = (NIN > 1)  ? $clog2(NIN)  : 1;
    localparam int OW   = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int CHW  = (K > 1)    ? $clog2(K)    : 1;
    localparam int RW   = (HO > 1)   ? $clog2(HO)   : 1;
    localparam int CW   = (WO > 1)   ? $clog2(WO)   : 1;

    localparam logic [CHW-1:0] CH_LAST  = CHW'(K - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(HO - 1);
    localparam logic [CW-1:0]  COL_LAST = CW'(WO - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            elem_q, elem_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic [DATA_WIDTH-1:0] m_q, m_d;

    logic                  wr_en;
    logic [IW-1:0]         in_idx;
    logic [OW-1:0]         out_idx;
    logic [DATA_WIDTH-1:0] x_word;
    logic [DATA_WIDTH-1:0] m_base;
    logic [DATA_WIDTH-1:0] m_next;

    logic [DATA_WIDTH-1:0] in_word [NIN];

    for (genvar gi = 0; gi < NIN; gi++) begin : g_in_word
        assign in_word[gi] = inputConv[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // elem[1] picks the lower row of the window, elem[0] the right column.
    always_comb begin
        in_idx  = (IW'(ch_q) * IW'(HI) + IW'({row_q, elem_q[1]})) * IW'(WI)
                  + IW'({col_q, elem_q[0]});
        out_idx = (OW'(ch_q) * OW'(HO) + OW'(row_q)) * OW'(WO) + OW'(col_q);
        x_word  = in_word[in_idx];
        m_base  = (elem_q == 2'd0) ? '0 : m_q;
        m_next  = (!x_word[DATA_WIDTH-1] &&
                   (x_word[DATA_WIDTH-2:0] > m_base[DATA_WIDTH-2:0])) ? x_word : m_base;
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        col_d   = col_q;
        row_d   = row_q;
        ch_d    = ch_q;
        m_d     = m_q;
        wr_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    elem_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    ch_d    = '0;
                    m_d     = '0;
                end
            end
            S_RUN: begin
                m_d = m_next;
                if (elem_q == 2'd3) begin
                    wr_en  = 1'b1;
                    elem_d = '0;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            if (ch_q == CH_LAST) begin
                                ch_d    = '0;
                                state_d = S_DONE;
                            end else begin
                                ch_d = ch_q + CHW'(1);
                            end
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    elem_d = elem_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            m_q     <= m_d;
        end
    end

    // Each output word only loads when its own window finishes.
    for (genvar gi = 0; gi < NOUT; gi++) begin : g_out_word
        logic [DATA_WIDTH-1:0] word_q, word_d;

        always_comb begin
            word_d = word_q;
            if (wr_en && (out_idx == OW'(gi))) begin
                word_d = m_d;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end

        assign outputPool[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_max_pool_relu_seq.sv
// Scoreboard bench for max_pool_relu_seq: small K=2 4x4 instance for the directed
// scenarios, plus a default-size instance for the full-length ramp.
module tb_max_pool_relu_seq;
    localparam int SIN  = 32;
    localparam int SOUT = 8;
    localparam int PW   = SOUT * 32;
    localparam int BIN  = 6 * 28 * 28;
    localparam int BOUT = 6 * 14 * 14;

    logic clk;
    logic reset, start;
    logic [SIN*32-1:0] in_s;
    logic [PW-1:0]     out_s;
    logic busy, done;

    logic reset_b, start_b;
    logic [BIN*32-1:0]  in_b;
    logic [BOUT*32-1:0] out_b;
    logic busy_b, done_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int busy_cnt = 0;

    typedef struct {
        int            done_cyc;
        logic [PW-1:0] pool;
    } exp_t;
    exp_t sb_q[$];
    int   big_q[$];
    logic [31:0] exp_w [8];

    max_pool_relu_seq #(.DATA_WIDTH(32), .K(2), .HI(4), .WI(4)) dut_s (
        .clk(clk), .reset(reset), .start(start), .inputConv(in_s),
        .outputPool(out_s), .busy(busy), .done(done)
    );

    max_pool_relu_seq #(.DATA_WIDTH(32), .K(6), .HI(28), .WI(28)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .inputConv(in_b),
        .outputPool(out_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end else begin
            $display("ok   %s at cycle %0d: %h", name, cyc, act);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < SIN; i++) in_s[i*32 +: 32] = 32'(i);
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < SIN; i++) in_s[i*32 +: 32] = v;
    endtask

    task automatic push_exp(input int dc);
        exp_t e;
        e.done_cyc = dc;
        for (int i = 0; i < SOUT; i++) e.pool[i*32 +: 32] = exp_w[i];
        sb_q.push_back(e);
    endtask

    // Monitor: every done pulse pops one expected result.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", PW'(1), PW'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("done_cycle", PW'(cyc), PW'(e.done_cyc));
                    check("pool_result", out_s, e.pool);
                    check("busy_cycles", PW'(busy_cnt), PW'(32));
                    check("busy_low_in_done", PW'(busy), PW'(0));
                end
                busy_cnt = 0;
            end
        end
    end

    initial forever begin
        int dc;
        @(negedge clk);
        if (done_b) begin
            if (big_q.size() == 0) begin
                check("big_unexpected_done", PW'(1), PW'(0));
            end else begin
                dc = big_q.pop_front();
                check("big_done_cycle", PW'(cyc), PW'(dc));
                check("big_out_5_13_13", PW'(out_b[(BOUT-1)*32 +: 32]), PW'(32'd4703));
                check("big_out_0_0_0", PW'(out_b[0 +: 32]), PW'(32'd29));
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1; reset_b = 1'b1;
        start = 1'b1; start_b = 1'b0;
        in_s = '0; in_b = '0;
        fill_ramp();
        for (int i = 0; i < BIN; i++) in_b[i*32 +: 32] = 32'(i);

        // Reset held with start asserted
        wait_cyc(2);
        check("reset_pool", out_s, PW'(0));
        check("reset_busy", PW'(busy), PW'(0));
        check("reset_done", PW'(done), PW'(0));
        reset = 1'b0; reset_b = 1'b0; start = 1'b0;
        @(negedge clk); @(negedge clk);
        check("no_run_after_reset_start", PW'(busy), PW'(0));

        // Ramp with write-back timing
        exp_w = '{32'd5, 32'd7, 32'd13, 32'd15, 32'd21, 32'd23, 32'd29, 32'd31};
        t = cyc; start = 1'b1; push_exp(t + 33);
        @(negedge clk); start = 1'b0;
        check("ramp_busy_t1", PW'(busy), PW'(1));
        wait_cyc(t + 4);
        check("ramp_w0_t4", PW'(out_s[0 +: 32]), PW'(0));
        wait_cyc(t + 5);
        check("ramp_w0_t5", PW'(out_s[0 +: 32]), PW'(5));
        wait_cyc(t + 32);
        check("ramp_w7_t32", PW'(out_s[7*32 +: 32]), PW'(0));
        wait_cyc(t + 33);
        check("ramp_w7_t33", PW'(out_s[7*32 +: 32]), PW'(31));
        wait_cyc(t + 34);

        // Handshake abuse, then an all-negative run over the ramp result
        t = cyc; start = 1'b1; push_exp(t + 33);
        @(negedge clk); start = 1'b0;
        wait_cyc(t + 3);  start = 1'b1; @(negedge clk); start = 1'b0;
        wait_cyc(t + 20); start = 1'b1; @(negedge clk); start = 1'b0;
        wait_cyc(t + 33); start = 1'b1;
        check("hs_done_t33", PW'(done), PW'(1));
        @(negedge clk); start = 1'b0;
        check("hs_idle_busy_t34", PW'(busy), PW'(0));
        check("hs_idle_done_t34", PW'(done), PW'(0));
        fill_const(32'hBF800000);
        exp_w = '{default: 32'h0};
        t = cyc; start = 1'b1; push_exp(t + 33);
        @(negedge clk); start = 1'b0;
        check("neg_restart_busy", PW'(busy), PW'(1));
        wait_cyc(t + 34);

        // Mixed signs, -0.0, +Inf and NaN
        fill_ramp();
        in_s[0*32 +: 32] = 32'h3F800000;
        in_s[1*32 +: 32] = 32'hC0000000;
        in_s[4*32 +: 32] = 32'h40400000;
        in_s[5*32 +: 32] = 32'h80000000;
        in_s[2*32 +: 32] = 32'h80000000;
        in_s[3*32 +: 32] = 32'h80000000;
        in_s[6*32 +: 32] = 32'h80000000;
        in_s[7*32 +: 32] = 32'h80000000;
        in_s[29*32 +: 32] = 32'h7F800000;
        in_s[26*32 +: 32] = 32'h7FC00000;
        exp_w = '{32'h40400000, 32'h0, 32'd13, 32'd15, 32'd21, 32'd23, 32'h7F800000, 32'h7FC00000};
        t = cyc; start = 1'b1; push_exp(t + 33);
        @(negedge clk); start = 1'b0;
        wait_cyc(t + 34);

        // Reset mid-run aborts with no done
        fill_ramp();
        t = cyc; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_cyc(t + 10); reset = 1'b1;
        wait_cyc(t + 11);
        check("midrst_busy", PW'(busy), PW'(0));
        check("midrst_pool", out_s, PW'(0));
        wait_cyc(t + 12); reset = 1'b0;
        wait_cyc(t + 40);
        check("midrst_still_idle", PW'(busy), PW'(0));
        check("midrst_pool_later", out_s, PW'(0));

        exp_w = '{32'd5, 32'd7, 32'd13, 32'd15, 32'd21, 32'd23, 32'd29, 32'd31};
        t = cyc; start = 1'b1; push_exp(t + 33);
        @(negedge clk); start = 1'b0;
        wait_cyc(t + 36);
        check("small_sb_drained", PW'(sb_q.size()), PW'(0));

        // Default-size ramp
        t = cyc; start_b = 1'b1; big_q.push_back(t + 4705);
        @(negedge clk); start_b = 1'b0;
        wait_cyc(t + 4712);
        check("big_sb_drained", PW'(big_q.size()), PW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
